// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF->ID pipeline register built from STAGES back-to-back slices.
// Each slice holds {valid, instr, pc, pc4}. The register adds a valid bit, a global
// stall (hold) and a flush (bubble insertion) on top of a plain delay line.
// Optional feature: define IF_ID_PERF_CNT_EN to add the bubble_count port and counter.
//
// Handshake: valid_in marks a real instruction on the inputs. The entry is captured
// only on an edge with RESET=0, FLUSH=0 and STALL=0. On a STALL edge the inputs are
// dropped and fetch must hold its PC. On a FLUSH edge the inputs are squashed and fetch
// must re-present the target on the next cycle. valid_out marks a real entry for decode.
module if_id_pipe_reg #(
  parameter int              XLEN      = 32,
  parameter int              STAGES    = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            valid_in,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PC4,
  output logic            valid_out,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC4_out
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_count
`endif
);

  // Reject illegal depths at elaboration time.
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("if_id_pipe_reg: STAGES must be in 1..4");
  end

  logic            valid_q [STAGES];
  logic [XLEN-1:0] instr_q [STAGES];
  logic [XLEN-1:0] pc_q    [STAGES];
  logic [XLEN-1:0] pc4_q   [STAGES];

  logic            valid_d [STAGES];
  logic [XLEN-1:0] instr_d [STAGES];
  logic [XLEN-1:0] pc_d    [STAGES];
  logic [XLEN-1:0] pc4_d   [STAGES];

  // Next slice contents: flush bubbles everything, stall holds, otherwise shift.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (FLUSH) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k] = 1'b0;
        instr_d[k] = NOP_INSTR;
        pc_d[k]    = '0;
        pc4_d[k]   = '0;
      end
    end else if (!STALL) begin
      // Slice 0 captures a bubble rather than the payload when fetch has nothing real.
      valid_d[0] = valid_in;
      instr_d[0] = valid_in ? instruction : NOP_INSTR;
      pc_d[0]    = valid_in ? PC  : '0;
      pc4_d[0]   = valid_in ? PC4 : '0;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        instr_d[k] = instr_q[k-1];
        pc_d[k]    = pc_q[k-1];
        pc4_d[k]   = pc4_q[k-1];
      end
    end
  end

  // Slice registers; reset outranks flush and stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        instr_q[k] <= NOP_INSTR;
        pc_q[k]    <= '0;
        pc4_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_out       = valid_q[STAGES-1];
  assign instruction_out = instr_q[STAGES-1];
  assign PC_out          = pc_q[STAGES-1];
  assign PC4_out         = pc4_q[STAGES-1];

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] bubble_count_q;
  logic [31:0] bubble_count_d;

  // Count every edge that sees a bubble at the decode side, saturating at all-ones.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (!valid_q[STAGES-1] && (bubble_count_q != 32'hFFFF_FFFF)) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed and random stimulus for if_id_pipe_reg, checked against
// a queue model of the in-flight entries.
module tb_if_id_pipe_reg;
  localparam int          XLEN   = 32;
  localparam int          STAGES = 2;
  localparam int          EW     = 1 + 3 * XLEN;
  localparam logic [31:0] NOP    = 32'h00000013;

  // Clock / reset block
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RESET = 1'b0;
  logic            STALL = 1'b0;
  logic            FLUSH = 1'b0;
  logic            valid_in = 1'b0;
  logic [XLEN-1:0] instruction = '0;
  logic [XLEN-1:0] PC = '0;
  logic [XLEN-1:0] PC4 = '0;
  logic            valid_out;
  logic [XLEN-1:0] instruction_out;
  logic [XLEN-1:0] PC_out;
  logic [XLEN-1:0] PC4_out;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]     bubble_count;
`endif

  if_id_pipe_reg #(.XLEN(XLEN), .STAGES(STAGES), .NOP_INSTR(NOP)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .STALL(STALL),
    .FLUSH(FLUSH),
    .valid_in(valid_in),
    .instruction(instruction),
    .PC(PC),
    .PC4(PC4),
    .valid_out(valid_out),
    .instruction_out(instruction_out),
    .PC_out(PC_out),
    .PC4_out(PC4_out)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .bubble_count(bubble_count)
`endif
  );

  // Scoreboard: exp_q[0] is the newest entry, exp_q[$] is what decode should see.
  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_cnt = '0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] bubble_entry();
    return {1'b0, NOP, 32'd0, 32'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    e = exp_q[$];
    check({tag, "_valid"}, {31'd0, valid_out}, {31'd0, e[EW-1]});
    check({tag, "_instr"}, instruction_out, e[3*XLEN-1:2*XLEN]);
    check({tag, "_pc"},    PC_out,          e[2*XLEN-1:XLEN]);
    check({tag, "_pc4"},   PC4_out,         e[XLEN-1:0]);
`ifdef IF_ID_PERF_CNT_EN
    check({tag, "_bcnt"},  bubble_count,    exp_cnt);
`endif
  endtask

  // Driver: present one cycle of inputs, advance the model by the edge rules, check.
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic v, input logic [31:0] pc, input string tag);
    logic          prev_valid;
    logic [EW-1:0] e;
    @(negedge CLK);
    RESET       = rst;
    STALL       = stall;
    FLUSH       = flush;
    valid_in    = v;
    instruction = $urandom;
    PC          = pc;
    PC4         = pc + 32'd4;
    e           = exp_q[$];
    prev_valid  = e[EW-1];
    @(posedge CLK);
    if (rst || flush) begin
      for (int i = 0; i < STAGES; i++) exp_q[i] = bubble_entry();
    end else if (!stall) begin
      exp_q.push_front(v ? {1'b1, instruction, PC, PC4} : bubble_entry());
      void'(exp_q.pop_back());
    end
    if (rst) exp_cnt = '0;
    else if (!prev_valid && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < STAGES; i++) exp_q.push_back(bubble_entry());

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset");
    check("reset_valid_lit", {31'd0, valid_out}, 32'd0);
    check("reset_instr_lit", instruction_out, 32'h00000013);
    check("reset_pc_lit", PC_out, 32'h0);

    // Straight stream 0x100/0x104/0x108
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, "s1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, "s2");
    check("stream_pc_first", PC_out, 32'h100);
    check("stream_pc4_first", PC4_out, 32'h104);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h108, "s3");
    check("stream_pc_second", PC_out, 32'h104);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C, "s4");
    check("stream_pc_third", PC_out, 32'h108);

    // Stall three cycles with changing inputs: outputs frozen, dropped inputs never seen
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h900, "stall1");
    check("stall1_pc_lit", PC_out, 32'h108);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h904, "stall2");
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h908, "stall3");
    check("stall3_pc_lit", PC_out, 32'h108);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h110, "resume1");
    check("resume_pc_lit", PC_out, 32'h10C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h114, "resume2");
    check("resume2_pc_lit", PC_out, 32'h110);

    // Flush together with stall: flush wins, then target 0x200 arrives STAGES edges later
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, "flush");
    check("flush_valid_lit", {31'd0, valid_out}, 32'd0);
    check("flush_instr_lit", instruction_out, 32'h00000013);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, "target");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "after_target");
    check("target_pc_lit", PC_out, 32'h200);
    check("target_valid_lit", {31'd0, valid_out}, 32'd1);

    // Reset while stalled with valid entries held
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, "fill1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h404, "fill2");
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, "hold");
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h504, "rst_in_stall");
    check("rst_stall_valid_lit", {31'd0, valid_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "post_rst");

    // Leading bubbles then a valid stream (exercises the optional counter too)
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst2");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "lead_bubble");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h600 + 32'(4 * i), "lead_valid");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           {$urandom_range(0, 16'hFFFF), 2'b00} , "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
